// File: rtl/counter_ring_monitor.sv
// Decodes a one-hot ring bus to a binary index and checks that each step
// is a legal right-rotation, reporting wraps, faults and an error count.
module counter_ring_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_ring,
    input  logic             i_enable,
    input  logic             i_clear,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index,
    output logic             o_wrap,
    output logic             o_onehot_err,
    output logic             o_seq_err,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_err_count,
    output logic [1:0]       o_state
);

    localparam int OW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] prev_ring;
    logic             prev_en;
    logic [WIDTH-1:0] expected;
    logic [OW-1:0]    ones;
    logic [IDX_W-1:0] pos;
    logic             onehot_ok;
    logic             seq_ok;
    logic             valid_n;
    logic             wrap_n;
    logic             oh_err_n;
    logic             seq_err_n;
    logic             err;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_n;
    logic             sticky_n;

    always_comb begin
        ones = '0;
        pos  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_ring[i]) begin
                ones = ones + OW'(1);
                pos  = IDX_W'(i);
            end
        end
    end

    assign onehot_ok = (ones == OW'(1));
    assign expected  = prev_en ? {prev_ring[0], prev_ring[WIDTH-1:1]}
                               : prev_ring;
    assign seq_ok    = (i_ring == expected);

    always_comb begin
        valid_n   = 1'b0;
        wrap_n    = 1'b0;
        oh_err_n  = 1'b0;
        seq_err_n = 1'b0;
        state_n   = state;
        unique case (state)
            SYNC: begin
                if (onehot_ok) begin
                    valid_n = 1'b1;
                    state_n = LOCKED;
                end else begin
                    oh_err_n = 1'b1;
                end
            end
            LOCKED: begin
                if (!onehot_ok) begin
                    oh_err_n = 1'b1;
                    state_n  = FAULT;
                end else if (!seq_ok) begin
                    seq_err_n = 1'b1;
                    state_n   = FAULT;
                end else begin
                    valid_n = 1'b1;
                    wrap_n  = prev_en & prev_ring[0] & i_ring[WIDTH-1];
                end
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: begin
                state_n = SYNC;
            end
        endcase
        if (i_clear) begin
            state_n = SYNC;
        end
    end

    // Clear wipes history first so a same-cycle error still counts once.
    assign err      = oh_err_n | seq_err_n;
    assign cnt_base = i_clear ? '0 : o_err_count;
    assign cnt_n    = (err && (cnt_base != '1)) ? cnt_base + CNT_W'(1)
                                                : cnt_base;
    assign sticky_n = (o_err_sticky & ~i_clear) | err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= SYNC;
            prev_ring    <= '0;
            prev_en      <= 1'b0;
            o_valid      <= 1'b0;
            o_index      <= '0;
            o_wrap       <= 1'b0;
            o_onehot_err <= 1'b0;
            o_seq_err    <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_count  <= '0;
        end else begin
            state        <= state_n;
            prev_ring    <= i_ring;
            prev_en      <= i_enable;
            o_valid      <= valid_n;
            o_wrap       <= wrap_n;
            o_onehot_err <= oh_err_n;
            o_seq_err    <= seq_err_n;
            o_err_sticky <= sticky_n;
            o_err_count  <= cnt_n;
            if (onehot_ok) begin
                o_index <= pos;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_counter_ring_monitor.sv
// Randomized and directed bench for counter_ring_monitor against a
// behavioural reference model.
module tb_counter_ring_monitor;

    localparam int W  = 4;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] ring;
    logic         enable;
    logic         clear;
    logic         valid;
    logic [1:0]   index;
    logic         wrap;
    logic         oh_err;
    logic         seq_err;
    logic         sticky;
    logic [CW-1:0] count;
    logic [1:0]   state;

    int errors = 0;
    int checks = 0;

    // reference model
    int   m_state, m_index, m_count;
    logic [W-1:0] m_prev;
    logic m_pen, m_valid, m_wrap, m_oh, m_seq, m_sticky;

    counter_ring_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring),
        .i_enable(enable), .i_clear(clear),
        .o_valid(valid), .o_index(index), .o_wrap(wrap),
        .o_onehot_err(oh_err), .o_seq_err(seq_err),
        .o_err_sticky(sticky), .o_err_count(count),
        .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x);
        return W'((x >> 1) | (x << (W - 1)));
    endfunction

    function automatic int pos_of(input logic [W-1:0] x);
        int p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        return p;
    endfunction

    task automatic model_update(input logic [W-1:0] r, input logic e,
                                input logic c, input logic rst);
        bit oh, pok, sq, ohe, sqe;
        int p, q, want, ns;
        if (!rst) begin
            m_state = 0; m_prev = '0; m_pen = 0; m_valid = 0;
            m_index = 0; m_wrap = 0; m_oh = 0; m_seq = 0;
            m_sticky = 0; m_count = 0;
            return;
        end
        oh  = ($countones(r) == 1);
        pok = ($countones(m_prev) == 1);
        p = pos_of(r);
        q = pos_of(m_prev);
        want = m_pen ? (q + W - 1) % W : q;
        sq = oh && pok && (p == want);
        m_valid = 0; m_wrap = 0; ohe = 0; sqe = 0; ns = m_state;
        if (m_state == 0) begin
            if (oh) begin m_valid = 1; ns = 1; end else ohe = 1;
        end else if (m_state == 1) begin
            if (!oh) begin ohe = 1; ns = 2; end
            else if (!sq) begin sqe = 1; ns = 2; end
            else begin
                m_valid = 1;
                m_wrap = m_pen && (q == 0) && (p == W - 1);
            end
        end
        if (c) begin ns = 0; m_count = 0; m_sticky = 0; end
        if (ohe || sqe) begin
            m_sticky = 1;
            if (m_count < MAXC) m_count++;
        end
        if (oh) m_index = p;
        m_oh = ohe; m_seq = sqe;
        m_prev = r; m_pen = e; m_state = ns;
    endtask

    task automatic step(input logic [W-1:0] r, input logic e,
                        input logic c, input logic rst);
        @(negedge clk);
        ring = r; enable = e; clear = c; rst_n = rst;
        @(posedge clk);
        model_update(r, e, c, rst);
        #1;
    endtask

    task automatic test_reset;
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", index); end
        checks++; if ({wrap, oh_err, seq_err, sticky} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {wrap, oh_err, seq_err, sticky}); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    endtask

    task automatic test_lock_rotate;
        logic [W-1:0] r = 4'b0001;
        int exp_idx[8] = '{0, 3, 2, 1, 0, 3, 2, 1};
        for (int i = 0; i < 8; i++) begin
            step(r, 1'b1, 1'b0, 1'b1);
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL lock_state[%0d]: got %0d want 1", i, state); end
            checks++; if (index !== 2'(exp_idx[i])) begin errors++; $display("FAIL lock_index[%0d]: got %0d want %0d", i, index, exp_idx[i]); end
            checks++; if (wrap !== (exp_idx[i] == 3)) begin errors++; $display("FAIL lock_wrap[%0d]: got %0b", i, wrap); end
            checks++; if ({valid, oh_err, seq_err} !== 3'b100) begin errors++; $display("FAIL lock_flags[%0d]: got %b want 100", i, {valid, oh_err, seq_err}); end
            r = rotr(r);
        end
    endtask

    task automatic test_enable_hold;
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        step(4'b1000, 1'b1, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0, 1'b0, 1'b1);
            checks++; if (index !== 2'd2) begin errors++; $display("FAIL hold_index[%0d]: got %0d want 2", i, index); end
            checks++; if ({valid, seq_err, state} !== 4'b1001) begin errors++; $display("FAIL hold_flags[%0d]: got %b want 1001", i, {valid, seq_err, state}); end
        end
    endtask

    task automatic test_skip_fault;
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        step(4'b0010, 1'b1, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        step(4'b1000, 1'b1, 1'b0, 1'b1);
        step(4'b0010, 1'b1, 1'b0, 1'b1);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL skip_seq: got %0b want 1", seq_err); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL skip_state: got %0d want 2", state); end
        checks++; if ({valid, oh_err, sticky} !== 3'b001) begin errors++; $display("FAIL skip_flags: got %b want 001", {valid, oh_err, sticky}); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL skip_count: got %0d want 1", count); end
        checks++; if (index !== 2'd1) begin errors++; $display("FAIL skip_index: got %0d want 1", index); end
        step(4'b0010, 1'b1, 1'b0, 1'b1);
        checks++; if ({seq_err, state} !== 3'b010) begin errors++; $display("FAIL skip_pulse: got %b want 010", {seq_err, state}); end
    endtask

    task automatic test_onehot_fault;
        step(4'b0001, 1'b0, 1'b1, 1'b1);
        checks++; if ({state, count, sticky} !== 5'b0) begin errors++; $display("FAIL clr_fault: got %b want 00000", {state, count, sticky}); end
        step(4'b0001, 1'b0, 1'b0, 1'b1);
        step(4'b0110, 1'b0, 1'b0, 1'b1);
        checks++; if ({oh_err, seq_err, state} !== 4'b1010) begin errors++; $display("FAIL oh_first: got %b want 1010", {oh_err, seq_err, state}); end
        checks++; if (index !== 2'd0) begin errors++; $display("FAIL oh_index: got %0d want 0", index); end
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        checks++; if ({oh_err, count} !== 3'b001) begin errors++; $display("FAIL oh_second: got %b want 001", {oh_err, count}); end
        checks++; if (index !== 2'd0) begin errors++; $display("FAIL oh_hold: got %0d want 0", index); end
    endtask

    task automatic test_saturation;
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b1);
            checks++; if (count !== CW'(exp_cnt[i])) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); end
            checks++; if ({oh_err, state} !== 3'b100) begin errors++; $display("FAIL sat_flags[%0d]: got %b want 100", i, {oh_err, state}); end
        end
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL clr_err_count: got %0d want 1", count); end
        checks++; if ({sticky, state} !== 3'b100) begin errors++; $display("FAIL clr_err_flags: got %b want 100", {sticky, state}); end
    endtask

    task automatic test_reset_midrun;
        logic [W-1:0] r;
        step(4'b0010, 1'b1, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL mid_lock: got %0d want 1", state); end
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        checks++; if ({valid, index, wrap, oh_err, seq_err, sticky, count, state} !== 11'b0) begin errors++; $display("FAIL mid_reset: got %b want 0", {valid, index, wrap, oh_err, seq_err, sticky, count, state}); end
        r = W'(1) << $urandom_range(0, W - 1);
        step(r, 1'b1, 1'b0, 1'b1);
        checks++; if ({state, valid, seq_err} !== 4'b0110) begin errors++; $display("FAIL mid_relock: got %b want 0110", {state, valid, seq_err}); end
        checks++; if (index !== 2'(pos_of(r))) begin errors++; $display("FAIL mid_index: got %0d want %0d", index, pos_of(r)); end
    endtask

    task automatic test_random;
        logic [W-1:0] r;
        logic e, c, rs;
        for (int i = 0; i < 400; i++) begin
            r  = m_pen ? rotr(m_prev) : m_prev;
            if (r == '0 || $urandom_range(0, 9) == 0) r = W'($urandom_range(0, 15));
            e  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 49) != 0);
            step(r, e, c, rs);
            checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_state); end
            checks++; if (valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, valid, m_valid); end
            checks++; if (index !== 2'(m_index)) begin errors++; $display("FAIL rnd_index[%0d]: got %0d want %0d", i, index, m_index); end
            checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap[%0d]: got %0b want %0b", i, wrap, m_wrap); end
            checks++; if (oh_err !== m_oh) begin errors++; $display("FAIL rnd_oh[%0d]: got %0b want %0b", i, oh_err, m_oh); end
            checks++; if (seq_err !== m_seq) begin errors++; $display("FAIL rnd_seq[%0d]: got %0b want %0b", i, seq_err, m_seq); end
            checks++; if (sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky[%0d]: got %0b want %0b", i, sticky, m_sticky); end
            checks++; if (count !== CW'(m_count)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, m_count); end
        end
    endtask

    initial begin
        rst_n = 1'b0; ring = '0; enable = 1'b0; clear = 1'b0;
        test_reset;
        test_lock_rotate;
        test_enable_hold;
        test_skip_fault;
        test_onehot_fault;
        test_saturation;
        test_reset_midrun;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
